// File: rtl/apb_rr_master_if.sv
// Bundles the requester-side handshake and the APB master bus of apb_rr_master.
// The master modport is the arbiter's view; the slave modport is the requesters' and APB slave's view.
interface apb_rr_master_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_grant;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_slverr;
  logic                      rsp_timeout;

  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [DATA_W-1:0]         prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_grant, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_grant, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_rr_master.sv
// APB3 master sharing one slave among NUM_REQ requesters with round-robin arbitration
// and a pready watchdog that aborts a hung ACCESS phase with an error response.
module apb_rr_master #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            i_pclk,
  input  logic            i_preset,
  apb_rr_master_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_last;
  logic [IDX_W-1:0]    r_win;
  logic [CNT_W-1:0]    r_wcnt;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_rspv;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_slverr;
  logic                r_timeout;

  logic                w_found;
  logic [IDX_W-1:0]    w_pick;
  int                  w_idx;

  // Round-robin search begins just after the previous winner and wraps.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(r_last) + k) % NUM_REQ;
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(w_idx);
      end
    end
  end

  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      r_state   <= S_IDLE;
      r_last    <= IDX_W'(NUM_REQ - 1);
      r_win     <= '0;
      r_wcnt    <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_grant   <= '0;
      r_rspv    <= '0;
      r_rdata   <= '0;
      r_slverr  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_grant <= '0;
      r_rspv  <= '0;
      case (r_state)
        S_IDLE: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          if (w_found) begin
            r_win    <= w_pick;
            r_last   <= w_pick;
            r_pwrite <= bus.req_write[w_pick];
            r_paddr  <= bus.req_addr[w_pick*ADDR_W +: ADDR_W];
            r_pwdata <= bus.req_wdata[w_pick*DATA_W +: DATA_W];
            r_psel   <= 1'b1;
            r_grant  <= NUM_REQ'(1) << w_pick;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_wcnt    <= '0;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // A pready arriving on the last allowed cycle still completes normally.
          if (bus.pready) begin
            r_rdata   <= r_pwrite ? '0 : bus.prdata;
            r_slverr  <= bus.pslverr;
            r_timeout <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rspv    <= NUM_REQ'(1) << r_win;
            r_state   <= S_RESP;
          end else if (r_wcnt == CNT_W'(TIMEOUT - 1)) begin
            r_rdata   <= '0;
            r_slverr  <= 1'b1;
            r_timeout <= 1'b1;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rspv    <= NUM_REQ'(1) << r_win;
            r_state   <= S_RESP;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.psel        = r_psel;
  assign bus.penable     = r_penable;
  assign bus.pwrite      = r_pwrite;
  assign bus.paddr       = r_paddr;
  assign bus.pwdata      = r_pwdata;
  assign bus.req_grant   = r_grant;
  assign bus.rsp_valid   = r_rspv;
  assign bus.rsp_rdata   = r_rdata;
  assign bus.rsp_slverr  = r_slverr;
  assign bus.rsp_timeout = r_timeout;
endmodule

// File: tb/tb_apb_rr_master.sv
// Randomised scoreboard bench for apb_rr_master: a 64-word APB RAM slave with per-transfer
// wait states, a reference model predicting grant order and responses, and a decoupled monitor.
module tb_apb_rr_master;
  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam int HANG = TMO + 40;

  logic pclk   = 1'b0;
  logic preset = 1'b0;
  always #5 pclk = ~pclk;

  apb_rr_master_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_rr_master #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .i_pclk   (pclk),
    .i_preset (preset),
    .bus      (bus)
  );

  typedef struct { int id; logic [AW-1:0] addr; bit wr; } grant_t;
  typedef struct { int id; logic [DW-1:0] rdata; bit err; bit tmo; int acc; } rsp_t;

  grant_t expGrantQ[$];
  rsp_t   expRspQ[$];
  int     waitQ[$];
  int     total = 0;
  int     bad   = 0;

  // Request slots loaded before each round, plus the model's view of memory and arbitration.
  bit              reqWr[N];
  logic [AW-1:0]   reqAddr[N];
  logic [DW-1:0]   reqData[N];
  int              reqWait[N];
  bit   [DW-1:0]   modelMem[64];
  int              modelLast = N - 1;

  // APB slave: RAM below 0x40, error region above; pready after curWait ACCESS cycles.
  bit   [DW-1:0]   slaveMem[64];
  int              accCnt  = 0;
  int              curWait = 0;
  logic            inAccess;
  assign inAccess    = bus.psel & bus.penable;
  assign bus.pready  = inAccess && (accCnt == curWait);
  assign bus.pslverr = bus.pready && (bus.paddr >= 32'h40);
  assign bus.prdata  = (bus.paddr < 32'h40) ? slaveMem[bus.paddr[5:0]] : (32'hBAD0_0000 ^ bus.paddr);

  always @(posedge pclk) begin
    if (bus.psel && !bus.penable) begin
      if (waitQ.size() > 0) curWait <= waitQ.pop_front();
      else curWait <= 0;
    end
    if (inAccess && !bus.pready) accCnt <= accCnt + 1;
    else accCnt <= 0;
    if (bus.pready && bus.pwrite && bus.paddr < 32'h40) slaveMem[bus.paddr[5:0]] <= bus.pwdata;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT grants or responds.
  initial begin : monitor
    grant_t g;
    rsp_t   r;
    int     lowRun = 10;
    int     accRun = 0;
    forever begin
      @(negedge pclk);
      if (preset) begin
        lowRun = 10;
        accRun = 0;
      end else begin
        if (bus.psel) begin
          if (lowRun > 0) checkOutput("idleGap", 64'(lowRun >= 2), 64'(1));
          lowRun = 0;
        end else begin
          lowRun++;
        end
        if (bus.psel && bus.penable) accRun++;
        if (bus.req_grant != '0) begin
          if (expGrantQ.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL grantUnexpected: got=%0h expected=none", bus.req_grant);
          end else begin
            g = expGrantQ.pop_front();
            checkOutput("grantVec", 64'(bus.req_grant), 64'(1) << g.id);
            checkOutput("setupPhase", 64'({bus.psel, bus.penable}), 64'(2'b10));
            checkOutput("setupAddr", 64'(bus.paddr), 64'(g.addr));
            checkOutput("setupWrite", 64'(bus.pwrite), 64'(g.wr));
          end
          accRun = 0;
        end
        if (bus.rsp_valid != '0) begin
          if (expRspQ.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL rspUnexpected: got=%0h expected=none", bus.rsp_valid);
          end else begin
            r = expRspQ.pop_front();
            checkOutput("rspVec", 64'(bus.rsp_valid), 64'(1) << r.id);
            checkOutput("rspRdata", 64'(bus.rsp_rdata), 64'(r.rdata));
            checkOutput("rspSlverr", 64'(bus.rsp_slverr), 64'(r.err));
            checkOutput("rspTimeout", 64'(bus.rsp_timeout), 64'(r.tmo));
            checkOutput("accessLen", 64'(accRun), 64'(r.acc));
          end
        end
      end
    end
  end

  task automatic setReq(input int id, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input int w);
    reqWr[id]   = wr;
    reqAddr[id] = addr;
    reqData[id] = data;
    reqWait[id] = w;
  endtask

  task automatic driveFields();
    for (int i = 0; i < N; i++) begin
      bus.req_write[i]             = reqWr[i];
      bus.req_addr[i*AW +: AW]     = reqAddr[i];
      bus.req_wdata[i*DW +: DW]    = reqData[i];
    end
  endtask

  // Predicts the service order and responses for a round of simultaneous requests, then drives it.
  task automatic applyStimulus(input logic [N-1:0] mask);
    logic [N-1:0] pend = mask;
    logic [N-1:0] seen = '0;
    int id;
    int cyc = 0;
    grant_t g;
    rsp_t   r;
    while (pend != '0) begin
      id = -1;
      for (int k = 1; k <= N; k++)
        if (id < 0 && pend[(modelLast + k) % N]) id = (modelLast + k) % N;
      pend[id]  = 1'b0;
      modelLast = id;
      g.id = id; g.addr = reqAddr[id]; g.wr = reqWr[id];
      expGrantQ.push_back(g);
      waitQ.push_back(reqWait[id]);
      r.id = id;
      if (reqWait[id] >= TMO) begin
        r.rdata = '0; r.err = 1'b1; r.tmo = 1'b1; r.acc = TMO;
      end else begin
        r.tmo = 1'b0;
        r.acc = reqWait[id] + 1;
        r.err = (reqAddr[id] >= 32'h40);
        if (reqWr[id]) begin
          r.rdata = '0;
          if (!r.err) modelMem[reqAddr[id][5:0]] = reqData[id];
        end else begin
          r.rdata = r.err ? (32'hBAD0_0000 ^ reqAddr[id]) : modelMem[reqAddr[id][5:0]];
        end
      end
      expRspQ.push_back(r);
    end
    @(negedge pclk);
    driveFields();
    bus.req_valid = mask;
    while ((bus.req_valid != '0 || expRspQ.size() != 0) && cyc < 400) begin
      @(negedge pclk);
      #1;
      bus.req_valid = bus.req_valid & ~seen;
      seen = bus.req_grant & bus.req_valid;
      cyc++;
    end
    if (cyc >= 400) begin
      total++; bad++;
      $display("[TB] FAIL roundBudget: pending rsp=%0d expected=0", expRspQ.size());
      bus.req_valid = '0;
      expGrantQ.delete(); expRspQ.delete(); waitQ.delete();
    end
  endtask

  initial begin : stimulus
    int cyc;
    grant_t g;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #1 preset = 1'b1;
    repeat (3) @(negedge pclk);
    checkOutput("rstPsel", 64'(bus.psel), 64'(0));
    checkOutput("rstPenable", 64'(bus.penable), 64'(0));
    checkOutput("rstPaddr", 64'(bus.paddr), 64'(0));
    checkOutput("rstGrant", 64'(bus.req_grant), 64'(0));
    checkOutput("rstRspValid", 64'(bus.rsp_valid), 64'(0));
    checkOutput("rstRdata", 64'(bus.rsp_rdata), 64'(0));
    checkOutput("rstSlverr", 64'(bus.rsp_slverr), 64'(0));
    checkOutput("rstTimeout", 64'(bus.rsp_timeout), 64'(0));
    preset = 1'b0;
    repeat (2) @(negedge pclk);
    checkOutput("idlePsel", 64'(bus.psel), 64'(0));

    $display("[TB] single write then read-back");
    setReq(0, 1'b1, 32'h05, 32'hDEADBEEF, 1);
    applyStimulus(3'b001);
    setReq(0, 1'b0, 32'h05, 32'h0, 0);
    applyStimulus(3'b001);

    $display("[TB] two requesters, two rounds of writes");
    for (int r = 0; r < 2; r++) begin
      setReq(0, 1'b1, 32'(8 + r), $urandom, 1);
      setReq(1, 1'b1, 32'(16 + r), $urandom, 1);
      applyStimulus(3'b011);
    end

    $display("[TB] error region read");
    setReq(1, 1'b0, 32'h40, 32'h0, 0);
    applyStimulus(3'b010);

    $display("[TB] hung slave then normal transfer");
    setReq(2, 1'b0, 32'h10, 32'h0, HANG);
    applyStimulus(3'b100);
    setReq(2, 1'b1, 32'h11, 32'h1234_5678, 0);
    applyStimulus(3'b100);

    $display("[TB] pready on the watchdog's last cycle");
    setReq(0, 1'b0, 32'h44, 32'h0, TMO - 1);
    applyStimulus(3'b001);

    $display("[TB] random rounds");
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++)
        setReq(i, 1'($urandom % 2),
               ($urandom % 8 == 0) ? 32'(64 + $urandom % 16) : 32'($urandom % 64),
               $urandom,
               ($urandom % 10 == 0) ? TMO + 2 : int'($urandom % 4));
      applyStimulus(N'($urandom_range(7, 1)));
    end

    $display("[TB] reset during ACCESS");
    setReq(1, 1'b0, 32'h05, 32'h0, HANG);
    g.id = 1; g.addr = 32'h05; g.wr = 1'b0;
    expGrantQ.push_back(g);
    waitQ.push_back(HANG);
    @(negedge pclk);
    driveFields();
    bus.req_valid = 3'b010;
    cyc = 0;
    while (!(bus.psel && bus.penable) && cyc < 50) begin
      @(negedge pclk);
      cyc++;
    end
    if (cyc >= 50) begin
      total++; bad++;
      $display("[TB] FAIL accessBudget: psel=%0b penable=%0b expected=11", bus.psel, bus.penable);
    end
    bus.req_valid = '0;
    #2 preset = 1'b1;
    #1;
    checkOutput("abortPsel", 64'(bus.psel), 64'(0));
    checkOutput("abortPenable", 64'(bus.penable), 64'(0));
    checkOutput("abortRspValid", 64'(bus.rsp_valid), 64'(0));
    waitQ.delete();
    expGrantQ.delete();
    modelLast = N - 1;
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    repeat (3) @(negedge pclk);
    for (int i = 0; i < N; i++) setReq(i, 1'b0, 32'(i + 8), 32'h0, 1);
    applyStimulus(3'b111);

    repeat (3) @(negedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
